// File: rtl/cam_pixel_capture_pkg.sv
// Purpose: shared constants, FSM state encoding and pixel types for the camera capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default geometry, frame-buffer address width, state constants, RGB444 pixel
//           struct and a counter-width helper.
package cam_pixel_capture_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
    // Smallest address width that reaches every pixel of a default frame (19 bits).
    localparam int unsigned ADDR_W       = $clog2(FRAME_PIXELS);
    localparam int unsigned PIX_W        = 12;

    // Capture FSM encoding.
    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_SKIP = 2'd1;
    localparam logic [1:0] S_ARM  = 2'd2;
    localparam logic [1:0] S_CAP  = 2'd3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Purpose: bundles for the sensor byte stream and the frame-buffer write side.
// Latency: n/a (wiring only).
// Backpressure: none; both buses are push-only.
// cam_bus_if : vsync, href, cam_data  (master = sensor, slave = capture block)
// fb_wr_if   : wr_en, wr_addr, wr_data, frame_done, frame_err (master = capture block)
interface cam_bus_if;
    logic       vsync;
    logic       href;
    logic [7:0] cam_data;

    modport master (output vsync, href, cam_data);
    modport slave  (input  vsync, href, cam_data);
endinterface

interface fb_wr_if;
    import cam_pixel_capture_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;
    logic              frame_err;

    modport master (output wr_en, wr_addr, wr_data, frame_done, frame_err);
    modport slave  (input  wr_en, wr_addr, wr_data, frame_done, frame_err);
endinterface

// File: rtl/cam_pixel_capture_rgb565_to_444.sv
// Purpose: convert an RGB565 byte pair (high byte first) to a 12-bit RGB444 pixel.
// Latency: combinational.
// Backpressure: none.
// Ports: hi_i/lo_i = RGB565 high/low byte, pix_o = {R[3:0],G[3:0],B[3:0]}.
module rgb565_to_444
    import cam_pixel_capture_pkg::*;
(
    input  logic [7:0] hi_i,
    input  logic [7:0] lo_i,
    output rgb444_t    pix_o
);

    // Keep the top bits of each channel: R5->R4, G6->G4, B5->B4.
    assign pix_o.r = hi_i[7:4];
    assign pix_o.g = {hi_i[2:0], lo_i[7]};
    assign pix_o.b = lo_i[4:1];

    // Truncated LSBs of each channel.
    logic unused_bits;
    assign unused_bits = ^{hi_i[3], lo_i[6:5], lo_i[0]};

endmodule

// File: rtl/cam_pixel_capture.sv
// Purpose: capture RGB565 camera frames as RGB444 frame-buffer writes after skipping settling frames.
// Latency: a pixel's write strobe appears one cycle after the edge that samples its low byte.
// Backpressure: none; the sensor cannot be stalled, surplus pixels are dropped and flagged.
// Ports: clk_i pixel clock, rst_ni synchronous active-low reset, cam (sensor stream in),
//        fb (write strobe/address/data plus frame_done pulse and per-frame frame_err).
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned SKIP_FRAMES = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    cam_bus_if.slave  cam,
    fb_wr_if.master   fb
);

    localparam int unsigned LPW = cnt_width(H_ACTIVE + 1);
    localparam int unsigned LCW = cnt_width(V_ACTIVE + 1);
    localparam int unsigned SKW = cnt_width(SKIP_FRAMES);

    localparam logic [ADDR_W-1:0] FRAME_PIX_W = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [LPW-1:0]    H_ACT_W     = LPW'(H_ACTIVE);
    localparam logic [LPW-1:0]    LP_MAX      = LPW'(H_ACTIVE + 1);
    localparam logic [LCW-1:0]    V_ACT_W     = LCW'(V_ACTIVE);
    localparam logic [LCW-1:0]    LC_MAX      = LCW'(V_ACTIVE + 1);
    localparam logic [SKW-1:0]    SKIP_LAST   = SKW'(SKIP_FRAMES - 1);

    logic       vsync;
    logic       href;
    logic [7:0] cam_data;

    assign vsync    = cam.vsync;
    assign href     = cam.href;
    assign cam_data = cam.cam_data;

    // State and counters.
    logic [1:0]        state_q,    state_d;
    logic [SKW-1:0]    skip_cnt_q, skip_cnt_d;
    logic              vsync_q;
    logic              href_q;
    logic              phase_q,    phase_d;
    logic [7:0]        hi_q,       hi_d;
    logic [ADDR_W-1:0] pix_cnt_q,  pix_cnt_d;
    logic [LPW-1:0]    line_pix_q, line_pix_d;
    logic [LCW-1:0]    line_cnt_q, line_cnt_d;
    logic              err_acc_q,  err_acc_d;

    // Registered outputs.
    logic              wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    rgb444_t           wr_data_q,    wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q,  frame_err_d;

    logic    vs_rise;
    logic    vs_fall;
    logic    href_fall;
    logic    byte_ok;
    logic    line_end;
    logic    pix_err;
    logic    line_err;
    rgb444_t pix444;

    assign vs_rise   =  vsync & ~vsync_q;
    assign vs_fall   = ~vsync &  vsync_q;
    assign href_fall = ~href  &  href_q;
    assign byte_ok   =  href  & ~vsync;

    rgb565_to_444 u_conv (
        .hi_i  (hi_q),
        .lo_i  (cam_data),
        .pix_o (pix444)
    );

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        pix_cnt_d    = pix_cnt_q;
        line_pix_d   = line_pix_q;
        line_cnt_d   = line_cnt_q;
        err_acc_d    = err_acc_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        line_end     = 1'b0;
        pix_err      = 1'b0;
        line_err     = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (vsync) begin
                    state_d = (SKIP_FRAMES == 0) ? S_ARM : S_SKIP;
                end
            end

            S_SKIP: begin
                // The blanking interval we entered in does not count; each
                // later vsync rise closes one discarded frame.
                if (vs_rise) begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d    = S_ARM;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end

            S_ARM: begin
                if (vs_fall) begin
                    state_d    = S_CAP;
                    phase_d    = 1'b0;
                    pix_cnt_d  = '0;
                    line_pix_d = '0;
                    line_cnt_d = '0;
                    err_acc_d  = 1'b0;
                end
            end

            S_CAP: begin
                // A vsync rise with href still high closes the open line too.
                line_end = href_fall | (vs_rise & href);

                if (byte_ok) begin
                    if (!phase_q) begin
                        hi_d    = cam_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (line_pix_q != LP_MAX) begin
                            line_pix_d = line_pix_q + 1'b1;
                        end
                        if (pix_cnt_q < FRAME_PIX_W) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pix_cnt_q;
                            wr_data_d = pix444;
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end else begin
                            pix_err = 1'b1;
                        end
                    end
                end

                if (line_end) begin
                    // A dangling high byte (phase_q set) is simply dropped here.
                    phase_d    = 1'b0;
                    line_pix_d = '0;
                    if ((line_pix_q != H_ACT_W) || phase_q) begin
                        line_err = 1'b1;
                    end
                    if (line_cnt_q >= V_ACT_W) begin
                        line_err = 1'b1;
                    end
                    if (line_cnt_q != LC_MAX) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end

                err_acc_d = err_acc_q | pix_err | line_err;

                if (vs_rise) begin
                    state_d      = S_ARM;
                    frame_done_d = 1'b1;
                    frame_err_d  = err_acc_d | (line_cnt_d != V_ACT_W);
                end
            end

            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_SYNC;
            skip_cnt_q   <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pix_cnt_q    <= '0;
            line_pix_q   <= '0;
            line_cnt_q   <= '0;
            err_acc_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            vsync_q      <= vsync;
            href_q       <= href;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            pix_cnt_q    <= pix_cnt_d;
            line_pix_q   <= line_pix_d;
            line_cnt_q   <= line_cnt_d;
            err_acc_q    <= err_acc_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign fb.wr_en      = wr_en_q;
    assign fb.wr_addr    = wr_addr_q;
    assign fb.wr_data    = wr_data_q;
    assign fb.frame_done = frame_done_q;
    assign fb.frame_err  = frame_err_q;

endmodule
